period_meter: RTL



---
 rtl/period_meter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures the rising-to-rising period and high-phase length of a slow
// asynchronous signal in sys_clk cycles, strobes each result and flags a stalled input.
module period_meter #(
    parameter int                   CNT_WIDTH = 26,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT   = 26'd50_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 meas_valid,
    output logic                 timeout
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MEASURE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 sync1_q;
    logic                 sig_s_q;
    logic                 sig_d_q;
    logic [0:0]           state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_p_q,   cnt_p_d;
    logic [CNT_WIDTH-1:0] cnt_h_q,   cnt_h_d;
    logic [CNT_WIDTH-1:0] period_q,  period_d;
    logic [CNT_WIDTH-1:0] high_q,    high_d;
    logic                 valid_q,   valid_d;
    logic                 timeout_q, timeout_d;

    logic rise;
    logic at_limit;

    assign rise     = sig_s_q & ~sig_d_q;
    assign at_limit = (cnt_p_q == TIMEOUT);

    // The counter check runs before the edge check, so an edge arriving exactly when
    // the limit is reached restarts the measurement instead of publishing it.
    always_comb begin
        state_d   = state_q;
        cnt_p_d   = cnt_p_q;
        cnt_h_d   = cnt_h_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                cnt_p_d = '0;
                cnt_h_d = '0;
                if (rise) begin
                    state_d = S_MEASURE;
                    cnt_h_d = CNT_ONE;
                end
            end

            S_MEASURE: begin
                if (at_limit) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                    cnt_p_d   = '0;
                    if (rise) begin
                        cnt_h_d = CNT_ONE;
                    end else begin
                        cnt_h_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (rise) begin
                    period_d  = cnt_p_q + CNT_ONE;
                    high_d    = cnt_h_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_p_d   = '0;
                    cnt_h_d   = CNT_ONE;
                end else begin
                    cnt_p_d = cnt_p_q + CNT_ONE;
                    cnt_h_d = cnt_h_q + {{(CNT_WIDTH-1){1'b0}}, sig_s_q};
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_p_d = '0;
                cnt_h_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= 1'b0;
            sig_s_q   <= 1'b0;
            sig_d_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_p_q   <= '0;
            cnt_h_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync1_q   <= sig_in;
            sig_s_q   <= sync1_q;
            sig_d_q   <= sig_s_q;
            state_q   <= state_d;
            cnt_p_q   <= cnt_p_d;
            cnt_h_q   <= cnt_h_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;

endmodule
